// File: rtl/gsau_wb_buffer_if.sv
// Handshake bundle between the GSAU writeback port, the writeback buffer and the vector RF.
// The buffer takes the slave side; the driving environment takes the master side.
interface gsau_wb_buffer_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DST_W  = 8
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] wb_psum;
    logic [DST_W-1:0]  wb_wbdst;
    logic              wb_valid;
    logic              wb_output_ready;
    logic [DATA_W-1:0] rf_wdata;
    logic [DST_W-1:0]  rf_wdst;
    logic              rf_wen;
    logic              rf_wready;
    logic              sb_retire;
    logic [DST_W-1:0]  sb_retire_vdst;
    logic [OCC_W-1:0]  occupancy;
    logic              ovf_err;

    modport slave (
        input  wb_psum, wb_wbdst, wb_valid, rf_wready,
        output wb_output_ready, rf_wdata, rf_wdst, rf_wen,
        output sb_retire, sb_retire_vdst, occupancy, ovf_err
    );

    modport master (
        output wb_psum, wb_wbdst, wb_valid, rf_wready,
        input  wb_output_ready, rf_wdata, rf_wdst, rf_wen,
        input  sb_retire, sb_retire_vdst, occupancy, ovf_err
    );
endinterface

// File: rtl/gsau_wb_buffer.sv
// In-order writeback FIFO from the GSAU to the vector RF write port, with scoreboard retire pulse.
// Define GSAU_WB_BYPASS_EN to let an empty buffer forward the GSAU input straight to the RF.
module gsau_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned DST_W  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    gsau_wb_buffer_if.slave     io_wb
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DST_W-1:0]  r_dst  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf_err;
    logic              r_retire;
    logic [DST_W-1:0]  r_retire_vdst;

    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_accept;
    logic              w_rf_wen;
    logic [DATA_W-1:0] w_rf_wdata;
    logic [DST_W-1:0]  w_rf_wdst;
`ifdef GSAU_WB_BYPASS_EN
    logic              w_bypass;
`endif

    always_comb begin
        w_full  = (r_count == FULL_CNT);
        w_empty = (r_count == '0);
        // Ready looks only at the count so the RF never reaches back to the GSAU combinationally.
        w_ready = !w_full;
`ifdef GSAU_WB_BYPASS_EN
        w_bypass   = w_empty && io_wb.wb_valid;
        w_rf_wen   = !w_empty || io_wb.wb_valid;
        w_rf_wdata = w_empty ? io_wb.wb_psum  : r_data[r_rd_ptr];
        w_rf_wdst  = w_empty ? io_wb.wb_wbdst : r_dst[r_rd_ptr];
        w_accept   = w_rf_wen && io_wb.rf_wready;
        // A bypassed beat accepted by the RF is never stored.
        w_push     = io_wb.wb_valid && w_ready && !(w_bypass && io_wb.rf_wready);
        w_pop      = !w_empty && io_wb.rf_wready;
`else
        w_rf_wen   = !w_empty;
        w_rf_wdata = r_data[r_rd_ptr];
        w_rf_wdst  = r_dst[r_rd_ptr];
        w_accept   = w_rf_wen && io_wb.rf_wready;
        w_push     = io_wb.wb_valid && w_ready;
        w_pop      = w_accept;
`endif
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= io_wb.wb_psum;
            r_dst[r_wr_ptr]  <= io_wb.wb_wbdst;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ovf_err     <= 1'b0;
            r_retire      <= 1'b0;
            r_retire_vdst <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (io_wb.wb_valid && !w_ready) begin
                r_ovf_err <= 1'b1;
            end
            r_retire <= w_accept;
            if (w_accept) begin
                r_retire_vdst <= w_rf_wdst;
            end
        end
    end

    assign io_wb.wb_output_ready = w_ready;
    assign io_wb.rf_wen          = w_rf_wen;
    assign io_wb.rf_wdata        = w_rf_wdata;
    assign io_wb.rf_wdst         = w_rf_wdst;
    assign io_wb.sb_retire       = r_retire;
    assign io_wb.sb_retire_vdst  = r_retire_vdst;
    assign io_wb.occupancy       = r_count;
    assign io_wb.ovf_err         = r_ovf_err;
endmodule

// File: doc/gsau_wb_buffer.md
# gsau_wb_buffer

- Writeback buffer directly downstream of the GSAU.
- Captures finished partial-sum vectors and their destination register indices from the GSAU's WB handshake.
- Queues them in an in-order FIFO and drains them into the vector register file write port.
- Emits a one-cycle retire pulse to the scoreboard for each vector actually written, so the destination register can be released.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DATA_W, 512, psum vector width (matches `vreg_t`)
- DST_W, 8, destination register index width

Clock and reset: one clock; reset is synchronous and active-high.

Ports (name  direction  width  meaning):
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- wb_psum  in  DATA_W  psum vector from GSAU
- wb_wbdst  in  DST_W  destination vreg for that psum
- wb_valid  in  1  GSAU offers a psum this cycle
- wb_output_ready  out  1  buffer can accept; equals (count < DEPTH)
- rf_wdata  out  DATA_W  write data to vector register file
- rf_wdst  out  DST_W  write index to vector register file
- rf_wen  out  1  write request valid
- rf_wready  in  1  register file accepts the write this cycle
- sb_retire  out  1  one-cycle pulse: a write completed
- sb_retire_vdst  out  DST_W  index of the retired register
- occupancy  out  $clog2(DEPTH)+1  current entry count
- ovf_err  out  1  sticky: wb_valid seen while wb_output_ready=0

## Operation
- Push = wb_valid && wb_output_ready. Push writes {wb_psum, wb_wbdst} at wr_ptr, then increments wr_ptr.
- Pop = rf_wen && rf_wready. Pop increments rd_ptr.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is a separate counter:
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- wb_output_ready depends only on count, never on rf_wready. There is no combinational path from the register file to the GSAU.
- When full, a same-cycle pop does not enable a push.
- rf_wen = (count != 0). rf_wdata and rf_wdst are driven combinationally from the entry at rd_ptr.
- rf_wen, rf_wdata and rf_wdst stay stable while rf_wen=1 and rf_wready=0.
- Strict FIFO order. Two entries with the same rf_wdst are written in arrival order; no merging.
- sb_retire and sb_retire_vdst are registered. Each pop in cycle t produces sb_retire=1 in cycle t+1, with sb_retire_vdst equal to the popped index.
- ovf_err sets when wb_valid=1 and wb_output_ready=0. The offered data is not stored; the GSAU must hold it. ovf_err clears only on RST.
- There is no separate FSM; state is {wr_ptr, rd_ptr, count, ovf_err, retire register}.

## Timing
- Reset values, applied at the clock edge with RST=1:
  - count=0, wr_ptr=0, rd_ptr=0
  - rf_wen=0, sb_retire=0, sb_retire_vdst=0, ovf_err=0
  - wb_output_ready=1, occupancy=0
- Reset mid-operation discards all queued entries; no retire pulses are issued for them.
- Latency without bypass:
  - push in cycle t → rf_wen=1 in cycle t+1
  - write accepted in cycle t+1 → sb_retire in cycle t+2
- Throughput: one push and one pop per cycle sustained.
- Full (count=DEPTH): wb_output_ready=0.
- Empty (count=0): rf_wen=0, and rf_wready is ignored.
- Simultaneous push and pop with count=1: the new entry becomes head in the next cycle, and occupancy stays 1.

## Configuration
- Macro: `GSAU_WB_BYPASS_EN`.
- Defined: when count=0 and wb_valid=1, the input drives rf_wen/rf_wdata/rf_wdst combinationally in the same cycle.
  - If rf_wready=1, the entry is consumed without being stored (count stays 0), and sb_retire pulses in the next cycle.
  - If rf_wready=0, the entry is pushed normally.
  - Zero-cycle latency through an empty buffer.
- Undefined: no bypass path; the minimum latency is one cycle as specified above.

## Test plan
- Reset, then a single push (psum=512'hA5…A5, dst=8'd3) with rf_wready=1 → rf_wen=1 with dst=3 in cycle t+1, sb_retire=1 with vdst=3 in cycle t+2, occupancy returns to 0.
- Four pushes (dst 0–3) with rf_wready=0 → wb_output_ready=0 after the 4th, occupancy=4. A 5th wb_valid sets ovf_err=1 with occupancy unchanged. Then rf_wready=1 → writes drain in order 0,1,2,3.
- Continuous push and pop every cycle for 20 beats with incrementing dst → occupancy holds at 1, retire sequence matches push sequence, and the pointers wrap cleanly.
- Same dst=7 pushed twice with different data → two register file writes in arrival order, two sb_retire pulses.
- RST asserted with occupancy=3 → next cycle rf_wen=0, occupancy=0, no sb_retire, ovf_err=0.
- With `GSAU_WB_BYPASS_EN`, empty buffer, wb_valid=1, rf_wready=1, dst=9 → rf_wen=1 in the same cycle, occupancy stays 0, sb_retire with vdst=9 in the next cycle.
